// File: rtl/hwag_sync_pkg.sv
// rtl/hwag_sync_pkg.sv - shared state encoding and default widths for the HWAG crank sync block
package hwag_sync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2,
        SYNC   = 2'd3
    } state_t;

    localparam int TCNT_W_DEF = 8;
    localparam int CONF_W_DEF = 4;

endpackage

// File: rtl/hwag_tooth_cnt.sv
// rtl/hwag_tooth_cnt.sv - tooth index counter with clear/increment and last-tooth compare
module hwag_tooth_cnt #(
    parameter int TCNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [TCNT_W-1:0] teeth_cfg_i,
    output logic [TCNT_W-1:0] tcnt_o,
    output logic              last_o
);

    logic [TCNT_W-1:0] tcnt_q;
    logic [TCNT_W-1:0] tcnt_d;

    // last_o marks the tooth just before the gap; the FSM never increments past it
    assign last_o = (tcnt_q == (teeth_cfg_i - TCNT_W'(1)));
    assign tcnt_o = tcnt_q;

    always_comb begin
        tcnt_d = tcnt_q;
        if (clr_i) begin
            tcnt_d = '0;
        end else if (inc_i) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

endmodule

// File: rtl/hwag_sync_ctrl.sv
// rtl/hwag_sync_ctrl.sv - crank-wheel SEARCH/VERIFY/SYNC sequencer; HWAG_SYNC_LOSS_CNT_EN adds loss_cnt_o
module hwag_sync_ctrl
    import hwag_sync_pkg::*;
#(
    parameter int TCNT_W = TCNT_W_DEF,
    parameter int CONF_W = CONF_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ena_i,
    input  logic              edge_i,
    input  logic              ovf_i,
    input  logic              pcap_ok_i,
    input  logic              gap_i,
    input  logic [TCNT_W-1:0] teeth_cfg_i,
    input  logic [CONF_W-1:0] confirm_cfg_i,
    output logic [1:0]        state_o,
    output logic [TCNT_W-1:0] tcnt_o,
    output logic              sync_o,
    output logic              sync_pls_o,
    output logic              lost_pls_o,
    output logic              err_early_o,
    output logic              err_miss_o
`ifdef HWAG_SYNC_LOSS_CNT_EN
    ,
    output logic [7:0]        loss_cnt_o
`endif
);

    state_t            state_q, state_d;
    logic [CONF_W-1:0] conf_q, conf_d;
    logic [CONF_W-1:0] conf_inc;
    logic [CONF_W-1:0] cfg_eff;
    logic              edge_q;
    logic              sync_pls_q, sync_pls_d;
    logic              lost_q, lost_d;
    logic              early_q, early_d;
    logic              miss_q, miss_d;
    logic              tcnt_clr, tcnt_inc, tcnt_last;

    hwag_tooth_cnt #(.TCNT_W(TCNT_W)) u_tooth_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (tcnt_clr),
        .inc_i       (tcnt_inc),
        .teeth_cfg_i (teeth_cfg_i),
        .tcnt_o      (tcnt_o),
        .last_o      (tcnt_last)
    );

    assign cfg_eff  = (confirm_cfg_i == '0) ? CONF_W'(1) : confirm_cfg_i;
    assign conf_inc = (conf_q == '1) ? conf_q : conf_q + CONF_W'(1);

    always_comb begin
        state_d    = state_q;
        conf_d     = conf_q;
        tcnt_clr   = 1'b0;
        tcnt_inc   = 1'b0;
        sync_pls_d = 1'b0;
        lost_d     = 1'b0;
        early_d    = 1'b0;
        miss_d     = 1'b0;
        if (!ena_i) begin
            state_d  = IDLE;
            conf_d   = '0;
            tcnt_clr = 1'b1;
        end else if (state_q == IDLE) begin
            state_d  = SEARCH;
            conf_d   = '0;
            tcnt_clr = 1'b1;
        end else if (ovf_i) begin
            state_d  = SEARCH;
            conf_d   = '0;
            tcnt_clr = 1'b1;
            lost_d   = (state_q == SYNC);
        end else if (edge_q) begin
            if (state_q == SEARCH) begin
                if (pcap_ok_i && gap_i) begin
                    tcnt_clr = 1'b1;
                    conf_d   = CONF_W'(1);
                    if (cfg_eff <= CONF_W'(1)) begin
                        state_d    = SYNC;
                        sync_pls_d = 1'b1;
                    end else begin
                        state_d = VERIFY;
                    end
                end
            end else if (pcap_ok_i && gap_i && tcnt_last) begin
                tcnt_clr = 1'b1;
                if (state_q == VERIFY) begin
                    conf_d = conf_inc;
                    if (conf_inc >= cfg_eff) begin
                        state_d    = SYNC;
                        sync_pls_d = 1'b1;
                    end
                end
            end else if (pcap_ok_i && !gap_i && !tcnt_last) begin
                tcnt_inc = 1'b1;
            end else begin
                // bad period, early gap or missing gap all drop back to SEARCH
                early_d  = pcap_ok_i && gap_i;
                miss_d   = pcap_ok_i && !gap_i;
                state_d  = SEARCH;
                conf_d   = '0;
                tcnt_clr = 1'b1;
                lost_d   = (state_q == SYNC);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            conf_q     <= '0;
            edge_q     <= 1'b0;
            sync_pls_q <= 1'b0;
            lost_q     <= 1'b0;
            early_q    <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            conf_q     <= conf_d;
            edge_q     <= edge_i;
            sync_pls_q <= sync_pls_d;
            lost_q     <= lost_d;
            early_q    <= early_d;
            miss_q     <= miss_d;
        end
    end

    assign state_o     = state_q;
    assign sync_o      = (state_q == SYNC);
    assign sync_pls_o  = sync_pls_q;
    assign lost_pls_o  = lost_q;
    assign err_early_o = early_q;
    assign err_miss_o  = miss_q;

`ifdef HWAG_SYNC_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (!ena_i) begin
            loss_cnt_d = '0;
        end else if (lost_d && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt_o = loss_cnt_q;
`endif

endmodule
